gpu_loader: RTL and testbench

Host-side load controller sitting directly upstream of the GPU core. It accepts a byte stream over a valid/ready handshake, parses write/run/halt packets, and drives the core's external load port: `ext_write_address`, `ext_write_data`, `ext_enable_write_inst`, `ext_enable_write_data`, `run`, and the core reset. It owns the whole load-then-run sequence, so the host never toggles core pins directly.

---
 rtl/gpu_loader_if.sv | 9 +
 rtl/gpu_loader.sv | 164 ++++++++++++++++
 tb/tb_gpu_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_loader_if.sv
// Host byte-stream port of gpu_loader: one byte per transfer, valid/ready handshake.
interface gpu_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/gpu_loader.sv
// Packet-driven load/run controller for the GPU core's external load port.
// Optional trailing checksum on write packets: define GPU_LOADER_CHECKSUM_EN.
module gpu_loader #(
    parameter int CORE_RESET_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    gpu_loader_if.slave        host,
    output logic [15:0]        ext_write_address,
    output logic [31:0]        ext_write_data,
    output logic               ext_enable_write_inst,
    output logic               ext_enable_write_data,
    output logic               run,
    output logic               core_reset_n,
    output logic               busy,
    output logic               error
);

`ifdef GPU_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_CSUM
    } state_t;
    localparam state_t S_DONE = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_WRITE
    } state_t;
    localparam state_t S_DONE = S_IDLE;
`endif

    localparam logic [1:0] RST_CYC = 2'(CORE_RESET_CYCLES);

    state_t      state_q;
    logic        is_inst_q;
    logic [15:0] addr_q;
    logic [15:0] cnt_q;
    logic [1:0]  idx_q;
    logic [23:0] word_q;
    logic [15:0] waddr_q;
    logic [31:0] wdata_q;
    logic        inst_stb_q;
    logic        data_stb_q;
    logic        run_q;
    logic        core_rst_n_q;
    logic [1:0]  rst_cnt_q;
    logic        error_q;
    logic        accept;

`ifdef GPU_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_d;
    assign sum_d = sum_q + host.in_data;
`endif

    // Stall while a word is being written or the core is held in reset.
    assign host.in_ready = (state_q != S_WRITE) && core_rst_n_q;
    assign accept        = host.in_valid && host.in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            waddr_q      <= 16'd0;
            wdata_q      <= 32'd0;
            inst_stb_q   <= 1'b0;
            data_stb_q   <= 1'b0;
            run_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            rst_cnt_q    <= RST_CYC;
            error_q      <= 1'b0;
        end else begin
            inst_stb_q <= 1'b0;
            data_stb_q <= 1'b0;
            if (rst_cnt_q != 2'd0) begin
                rst_cnt_q    <= rst_cnt_q - 2'd1;
                core_rst_n_q <= (rst_cnt_q == 2'd1);
            end
`ifdef GPU_LOADER_CHECKSUM_EN
            if (accept) sum_q <= sum_d;
`endif
            case (state_q)
                S_IDLE: if (accept) begin
                    case (host.in_data)
                        8'h00: error_q <= 1'b0;
                        8'h01, 8'h02: begin
                            is_inst_q <= (host.in_data == 8'h01);
                            state_q   <= S_ADDR0;
`ifdef GPU_LOADER_CHECKSUM_EN
                            sum_q     <= host.in_data;
`endif
                            // Loading into a running core implies a halt first.
                            if (run_q) begin
                                run_q        <= 1'b0;
                                core_rst_n_q <= 1'b0;
                                rst_cnt_q    <= RST_CYC;
                            end
                        end
                        8'h03: run_q <= 1'b1;
                        8'h04: begin
                            run_q        <= 1'b0;
                            core_rst_n_q <= 1'b0;
                            rst_cnt_q    <= RST_CYC;
                        end
                        default: error_q <= 1'b1;
                    endcase
                end
                S_ADDR0: if (accept) begin
                    addr_q[7:0] <= host.in_data;
                    state_q     <= S_ADDR1;
                end
                S_ADDR1: if (accept) begin
                    addr_q[15:8] <= host.in_data;
                    state_q      <= S_CNT0;
                end
                S_CNT0: if (accept) begin
                    cnt_q[7:0] <= host.in_data;
                    state_q    <= S_CNT1;
                end
                S_CNT1: if (accept) begin
                    cnt_q[15:8] <= host.in_data;
                    idx_q       <= 2'd0;
                    state_q     <= ({host.in_data, cnt_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                end
                S_DATA: if (accept) begin
                    idx_q <= idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_q[7:0]   <= host.in_data;
                        2'd1: word_q[15:8]  <= host.in_data;
                        2'd2: word_q[23:16] <= host.in_data;
                        default: begin
                            waddr_q    <= addr_q;
                            wdata_q    <= {host.in_data, word_q};
                            inst_stb_q <= is_inst_q;
                            data_stb_q <= !is_inst_q;
                            state_q    <= S_WRITE;
                        end
                    endcase
                end
                S_WRITE: begin
                    addr_q  <= addr_q + 16'd4;
                    cnt_q   <= cnt_q - 16'd1;
                    state_q <= (cnt_q == 16'd1) ? S_DONE : S_DATA;
                end
`ifdef GPU_LOADER_CHECKSUM_EN
                S_CSUM: if (accept) begin
                    if (sum_d != 8'd0) error_q <= 1'b1;
                    state_q <= S_IDLE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ext_write_address     = waddr_q;
    assign ext_write_data        = wdata_q;
    assign ext_enable_write_inst = inst_stb_q;
    assign ext_enable_write_data = data_stb_q;
    assign run                   = run_q;
    assign core_reset_n          = core_rst_n_q;
    assign busy                  = (state_q != S_IDLE);
    assign error                 = error_q;

endmodule

// File: tb/tb_gpu_loader.sv
// Bench for gpu_loader: packet-level reference model, per-cycle compare, directed literals and random packets.
module tb_gpu_loader;
    localparam int C = 2;
`ifdef GPU_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ext_write_address;
    logic [31:0] ext_write_data;
    logic        ext_enable_write_inst;
    logic        ext_enable_write_data;
    logic        run;
    logic        core_reset_n;
    logic        busy;
    logic        error;

    gpu_loader_if bus ();

    gpu_loader #(.CORE_RESET_CYCLES(C)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .host                  (bus),
        .ext_write_address     (ext_write_address),
        .ext_write_data        (ext_write_data),
        .ext_enable_write_inst (ext_enable_write_inst),
        .ext_enable_write_data (ext_enable_write_data),
        .run                   (run),
        .core_reset_n          (core_reset_n),
        .busy                  (busy),
        .error                 (error)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (packet parser over accepted bytes) ----------------
    bit          started = 1'b0;
    bit          m_run, m_err, m_wr, m_winst, m_inst, m_ready, m_busy;
    int          m_pos, m_rlow, m_nbytes;
    logic [7:0]  m_sum;
    logic [7:0]  m_hdr [4];
    logic [15:0] m_addr, m_waddr;
    logic [31:0] m_word, m_wdata;

    function automatic void m_consume(input logic [7:0] b);
        int j;
        int k;
        if (m_pos == 0) begin
            case (b)
                8'h00: m_err = 1'b0;
                8'h03: m_run = 1'b1;
                8'h04: begin m_run = 1'b0; m_rlow = C; end
                8'h01, 8'h02: begin
                    if (m_run) begin m_run = 1'b0; m_rlow = C; end
                    m_inst = (b == 8'h01);
                    m_sum  = b;
                    m_pos  = 1;
                end
                default: m_err = 1'b1;
            endcase
        end else begin
            j = m_pos - 1;
            m_pos++;
            m_sum = m_sum + b;
            if (j < 4) begin
                m_hdr[j] = b;
                if (j == 3) begin
                    m_addr   = {m_hdr[1], m_hdr[0]};
                    m_nbytes = 4 * int'({m_hdr[3], m_hdr[2]});
                    if (m_nbytes == 0 && !CS_EN) m_pos = 0;
                end
            end else if (j - 4 < m_nbytes) begin
                k = j - 4;
                m_word[8*(k%4) +: 8] = b;
                if (k % 4 == 3) begin
                    m_wr    = 1'b1;
                    m_winst = m_inst;
                    m_wdata = m_word;
                    m_waddr = m_addr + 16'(4 * (k / 4));
                end
                if (k == m_nbytes - 1 && !CS_EN) m_pos = 0;
            end else begin
                if (m_sum != 8'd0) m_err = 1'b1;
                m_pos = 0;
            end
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            started = 1'b1;
            m_run = 1'b0; m_err = 1'b0; m_wr = 1'b0; m_winst = 1'b0;
            m_pos = 0; m_rlow = C; m_waddr = 16'd0; m_wdata = 32'd0;
        end else if (started) begin
            m_wr = 1'b0;
            if (m_rlow > 0) m_rlow--;
            if (bus.in_valid && m_ready) m_consume(bus.in_data);
        end
        m_ready = !m_wr && (m_rlow == 0);
        m_busy  = (m_pos != 0) || m_wr;
    end

    // ---------------- per-cycle compare ----------------
    typedef struct packed {
        logic        inst;
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog [$];

    always @(negedge clock) begin
        if (started) begin
            chk("in_ready",     32'(bus.in_ready),            32'(m_ready));
            chk("busy",         32'(busy),                    32'(m_busy));
            chk("run",          32'(run),                     32'(m_run));
            chk("core_reset_n", 32'(core_reset_n),            32'(m_rlow == 0));
            chk("error",        32'(error),                   32'(m_err));
            chk("strobe_inst",  32'(ext_enable_write_inst),   32'(m_wr && m_winst));
            chk("strobe_data",  32'(ext_enable_write_data),   32'(m_wr && !m_winst));
            chk("wr_addr",      32'(ext_write_address),       32'(m_waddr));
            chk("wr_data",      ext_write_data,               m_wdata);
            if (ext_enable_write_inst || ext_enable_write_data)
                wlog.push_back({ext_enable_write_inst, ext_write_address, ext_write_data});
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pkt [$];
    bit         gaps = 1'b0;

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic rdy;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        forever begin
            rdy = bus.in_ready;
            @(posedge clock);
            @(negedge clock);
            if (rdy) break;
            t++;
            if (t > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: byte 0x%0h not accepted within %0d cycles", b, t);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int cs_mode);
        logic [7:0] s;
        s = 8'd0;
        foreach (pkt[i]) s = s + pkt[i];
        if (CS_EN && cs_mode != 0 && (pkt[0] == 8'h01 || pkt[0] == 8'h02))
            pkt.push_back((cs_mode == 1) ? (8'd0 - s) : (8'd1 - s));
        foreach (pkt[i]) begin
            if (gaps && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
            send_byte(pkt[i]);
        end
    endtask

    task automatic build_write(input logic [7:0] cmd, input logic [15:0] addr, input int cnt);
        logic [31:0] w;
        pkt.delete();
        pkt.push_back(cmd);
        pkt.push_back(addr[7:0]);
        pkt.push_back(addr[15:8]);
        pkt.push_back(8'(cnt));
        pkt.push_back(8'(cnt >> 8));
        for (int i = 0; i < cnt; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) pkt.push_back(w[8*b +: 8]);
        end
    endtask

    initial begin
        int          kind;
        int          n;
        logic [15:0] a;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_run",          32'(run),          32'd0);
        chk("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_error",        32'(error),        32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_core_reset_n_1", 32'(core_reset_n), 32'd0);
        @(negedge clock);
        chk("post_rst_core_reset_n_2", 32'(core_reset_n), 32'd1);
        chk("post_rst_in_ready",       32'(bus.in_ready), 32'd1);
        idle(1);
        chk("idle_in_ready",           32'(bus.in_ready), 32'd1);

        // Two instruction words at 0x0010 / 0x0014.
        wlog.delete();
        pkt = '{8'h01, 8'h10, 8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        send_pkt(1);
        idle(3);
        chk("inst_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("inst0_kind", 32'(wlog[0].inst), 32'd1);
            chk("inst0_addr", 32'(wlog[0].a),    32'h0010);
            chk("inst0_data", wlog[0].d,         32'h00500513);
            chk("inst1_kind", 32'(wlog[1].inst), 32'd1);
            chk("inst1_addr", 32'(wlog[1].a),    32'h0014);
            chk("inst1_data", wlog[1].d,         32'h00100093);
        end

        // Data words straddling the top of the address space.
        wlog.delete();
        pkt = '{8'h02, 8'hFC, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                8'h55, 8'h55, 8'h55, 8'h55};
        send_pkt(1);
        idle(3);
        chk("wrap_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("wrap0_kind", 32'(wlog[0].inst), 32'd0);
            chk("wrap0_addr", 32'(wlog[0].a),    32'hFFFC);
            chk("wrap1_addr", 32'(wlog[1].a),    32'h0000);
            chk("wrap1_data", wlog[1].d,         32'h55555555);
        end

        // Run, then halt with the core reset pulse.
        chk("pre_run", 32'(run), 32'd0);
        send_byte(8'h03);
        chk("run_rise", 32'(run), 32'd1);
        send_byte(8'h04);
        chk("halt_run",        32'(run),          32'd0);
        chk("halt_core_rst_1", 32'(core_reset_n), 32'd0);
        chk("halt_ready_1",    32'(bus.in_ready), 32'd0);
        @(negedge clock);
        chk("halt_core_rst_2", 32'(core_reset_n), 32'd0);
        chk("halt_ready_2",    32'(bus.in_ready), 32'd0);
        @(negedge clock);
        chk("halt_core_rst_3", 32'(core_reset_n), 32'd1);
        chk("halt_ready_3",    32'(bus.in_ready), 32'd1);

        // Unknown command, then NOP clears the error.
        send_byte(8'h07);
        chk("bad_cmd_error", 32'(error), 32'd1);
        chk("bad_cmd_busy",  32'(busy),  32'd0);
        send_byte(8'h00);
        chk("nop_error",     32'(error), 32'd0);

        // Write into a running core halts it first.
        send_byte(8'h03);
        wlog.delete();
        pkt = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_pkt(1);
        idle(3);
        chk("implicit_halt_run",   32'(run),          32'd0);
        chk("implicit_halt_count", 32'(wlog.size()),  32'd1);
        if (wlog.size() == 1) chk("implicit_halt_data", wlog[0].d, 32'hDEADBEEF);

`ifdef GPU_LOADER_CHECKSUM_EN
        pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_pkt(0);
        idle(2);
        chk("csum_good_error", 32'(error), 32'd0);
        pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        idle(2);
        chk("csum_bad_error", 32'(error), 32'd1);
        send_byte(8'h00);
`endif

        // Random packet mix with idle gaps and mid-packet resets.
        gaps = 1'b1;
        for (int it = 0; it < 160; it++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 2) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15) & 12))
                                            : 16'($urandom);
            case (kind)
                0, 1, 2, 3: begin
                    build_write((kind < 2) ? 8'h01 : 8'h02, a, $urandom_range(0, 4));
                    send_pkt(1);
                end
                4: send_byte(8'h03);
                5: send_byte(8'h04);
                6: send_byte(8'h00);
                7: send_byte(8'($urandom_range(5, 255)));
                8: begin
                    build_write(8'h02, a, $urandom_range(1, 3));
                    n = $urandom_range(1, pkt.size() - 1);
                    for (int i = 0; i < n; i++) send_byte(pkt[i]);
                    reset = 1'b1;
                    idle($urandom_range(1, 2));
                    reset = 1'b0;
                end
                default: begin
                    build_write(8'h01, a, $urandom_range(0, 2));
                    send_pkt(2);
                end
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
